rp2a03_dmc: RTL

RP2A03_DMC -- requirements
Module: rp2a03_dmc

---
 rtl/rp2a03_apu_pkg.sv | 34 +++
 rtl/rp2a03_dmc_output.sv | 80 ++++++++
 rtl/rp2a03_dmc.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rp2a03_apu_pkg.sv
// Shared APU constants: DMC register offsets, sample base address and the
// NTSC DMC rate table.
package rp2a03_apu_pkg;

  localparam logic [1:0]  REG_CTRL  = 2'd0;  // $4010
  localparam logic [1:0]  REG_LEVEL = 2'd1;  // $4011
  localparam logic [1:0]  REG_ADDR  = 2'd2;  // $4012
  localparam logic [1:0]  REG_LEN   = 2'd3;  // $4013

  localparam logic [15:0] DMC_BASE_ADDR = 16'hC000;

  // Full timer period in CPU cycles for each rate index.
  function automatic logic [8:0] dmc_period(input logic [3:0] rate);
    case (rate)
      4'd0:    dmc_period = 9'd428;
      4'd1:    dmc_period = 9'd380;
      4'd2:    dmc_period = 9'd340;
      4'd3:    dmc_period = 9'd320;
      4'd4:    dmc_period = 9'd286;
      4'd5:    dmc_period = 9'd254;
      4'd6:    dmc_period = 9'd226;
      4'd7:    dmc_period = 9'd214;
      4'd8:    dmc_period = 9'd190;
      4'd9:    dmc_period = 9'd160;
      4'd10:   dmc_period = 9'd142;
      4'd11:   dmc_period = 9'd128;
      4'd12:   dmc_period = 9'd106;
      4'd13:   dmc_period = 9'd84;
      4'd14:   dmc_period = 9'd72;
      default: dmc_period = 9'd54;
    endcase
  endfunction

endpackage

// File: rtl/rp2a03_dmc_output.sv
// DMC output unit: rate timer, 8-bit shifter, bit counter, silence flag and
// the 7-bit delta-modulated output level.
module rp2a03_dmc_output
  import rp2a03_apu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_clk,
  input  logic [3:0] rate,
  input  logic       level_we,
  input  logic [6:0] level_din,
  input  logic       buf_full,
  input  logic [7:0] buf_data,
  output logic       buf_take,
  output logic [6:0] level
);

  logic [8:0] timer_q, timer_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bits_q, bits_d;
  logic       silence_q, silence_d;
  logic [6:0] level_q, level_d;

  always_comb begin
    timer_d   = timer_q;
    shift_d   = shift_q;
    bits_d    = bits_q;
    silence_d = silence_q;
    level_d   = level_q;
    buf_take  = 1'b0;
    if (timer_q == 9'd0) begin
      timer_d = dmc_period(rate) - 9'd1;
      // Saturating step: the level never wraps past 0 or 127.
      if (!silence_q) begin
        if (shift_q[0] && level_q <= 7'd125) begin
          level_d = level_q + 7'd2;
        end else if (!shift_q[0] && level_q >= 7'd2) begin
          level_d = level_q - 7'd2;
        end
      end
      shift_d = shift_q >> 1;
      bits_d  = bits_q - 4'd1;
      if (bits_q == 4'd1) begin
        bits_d = 4'd8;
        if (buf_full) begin
          shift_d   = buf_data;
          silence_d = 1'b0;
          buf_take  = 1'b1;
        end else begin
          silence_d = 1'b1;
        end
      end
    end else begin
      timer_d = timer_q - 9'd1;
    end
    // A direct level write beats the delta step on the same cycle.
    if (level_we) begin
      level_d = level_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= 9'd427;
      shift_q   <= 8'd0;
      bits_q    <= 4'd8;
      silence_q <= 1'b1;
      level_q   <= 7'd0;
    end else if (cpu_clk) begin
      timer_q   <= timer_d;
      shift_q   <= shift_d;
      bits_q    <= bits_d;
      silence_q <= silence_d;
      level_q   <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/rp2a03_dmc.sv
// RP2A03 delta modulation channel: registers, sample memory reader with a
// level DMA request, IRQ, and the output unit.
module rp2a03_dmc
  import rp2a03_apu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_clk,
  input  logic        reg_we,
  input  logic [1:0]  reg_addr,
  input  logic [7:0]  reg_din,
  input  logic        status_we,
  input  logic        status_din,
  output logic        dmc_trig,
  output logic [15:0] dmc_dma_addr,
  input  logic        dmc_ack,
  input  logic [7:0]  dma_data,
  output logic        irq,
  output logic        active,
  output logic [6:0]  dmc_out
);

  // DMA handshake: dmc_trig rises when the sample buffer is empty and bytes
  // remain, then holds until an enabled edge sees dmc_ack=1; that edge
  // consumes dma_data and drops dmc_trig.
  logic        irq_en_q, irq_en_d;
  logic        loop_q, loop_d;
  logic [3:0]  rate_q, rate_d;
  logic [15:0] sample_addr_q, sample_addr_d;
  logic [11:0] sample_len_q, sample_len_d;
  logic [15:0] cur_addr_q, cur_addr_d;
  logic [11:0] bytes_rem_q, bytes_rem_d;
  logic [7:0]  buf_q, buf_d;
  logic        buf_full_q, buf_full_d;
  logic        trig_q, trig_d;
  logic        irq_q, irq_d;
  logic        buf_take;

  always_comb begin
    irq_en_d      = irq_en_q;
    loop_d        = loop_q;
    rate_d        = rate_q;
    sample_addr_d = sample_addr_q;
    sample_len_d  = sample_len_q;
    cur_addr_d    = cur_addr_q;
    bytes_rem_d   = bytes_rem_q;
    buf_d         = buf_q;
    buf_full_d    = buf_full_q;
    trig_d        = trig_q;
    irq_d         = irq_q;

    if (trig_q && dmc_ack) begin
      buf_d      = dma_data;
      buf_full_d = 1'b1;
      trig_d     = 1'b0;
      cur_addr_d = (cur_addr_q == 16'hFFFF) ? 16'h8000 : cur_addr_q + 16'd1;
      if (bytes_rem_q != 12'd0) begin
        bytes_rem_d = bytes_rem_q - 12'd1;
        if (bytes_rem_q == 12'd1) begin
          if (loop_q) begin
            cur_addr_d  = sample_addr_q;
            bytes_rem_d = sample_len_q;
          end else if (irq_en_q) begin
            irq_d = 1'b1;
          end
        end
      end
    end else if (!trig_q && !buf_full_q && bytes_rem_q != 12'd0) begin
      trig_d = 1'b1;
    end

    if (buf_take) begin
      buf_full_d = 1'b0;
    end

    if (reg_we) begin
      case (reg_addr)
        REG_CTRL: begin
          irq_en_d = reg_din[7];
          loop_d   = reg_din[6];
          rate_d   = reg_din[3:0];
          if (!reg_din[7]) begin
            irq_d = 1'b0;
          end
        end
        REG_LEVEL: ;
        REG_ADDR:  sample_addr_d = DMC_BASE_ADDR + {2'b00, reg_din, 6'd0};
        REG_LEN:   sample_len_d  = {reg_din, 4'b0001};
      endcase
    end

    // A $4015 write lands last so a disable wins over the ack decrement.
    if (status_we) begin
      irq_d = 1'b0;
      if (!status_din) begin
        bytes_rem_d = 12'd0;
      end else if (bytes_rem_q == 12'd0) begin
        cur_addr_d  = sample_addr_q;
        bytes_rem_d = sample_len_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q      <= 1'b0;
      loop_q        <= 1'b0;
      rate_q        <= 4'd0;
      sample_addr_q <= DMC_BASE_ADDR;
      sample_len_q  <= 12'd1;
      cur_addr_q    <= DMC_BASE_ADDR;
      bytes_rem_q   <= 12'd0;
      buf_q         <= 8'd0;
      buf_full_q    <= 1'b0;
      trig_q        <= 1'b0;
      irq_q         <= 1'b0;
    end else if (cpu_clk) begin
      irq_en_q      <= irq_en_d;
      loop_q        <= loop_d;
      rate_q        <= rate_d;
      sample_addr_q <= sample_addr_d;
      sample_len_q  <= sample_len_d;
      cur_addr_q    <= cur_addr_d;
      bytes_rem_q   <= bytes_rem_d;
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
      trig_q        <= trig_d;
      irq_q         <= irq_d;
    end
  end

  rp2a03_dmc_output u_output (
    .clk       (clk),
    .rst       (rst),
    .cpu_clk   (cpu_clk),
    .rate      (rate_q),
    .level_we  (reg_we && reg_addr == REG_LEVEL),
    .level_din (reg_din[6:0]),
    .buf_full  (buf_full_q),
    .buf_data  (buf_q),
    .buf_take  (buf_take),
    .level     (dmc_out)
  );

  assign dmc_trig     = trig_q;
  assign dmc_dma_addr = cur_addr_q;
  assign irq          = irq_q;
  assign active       = (bytes_rem_q != 12'd0);

endmodule
